// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: buffers words in a small FIFO and shifts them out
// one bit per enabled cycle on a registered serial line.
module bit_serializer #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic [15:0]      words_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [AW:0]   DEPTH_COUNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT    = CW'(WIDTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      occ_reg;

  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    cnt_reg;
  logic             dout_reg;
  logic             dout_valid_reg;
  logic [15:0]      words_sent_reg;

  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_word;
  logic [WIDTH-1:0] head_ordered;

  assign fifo_empty = (occ_reg == '0);
  assign in_ready   = !rst && (occ_reg < DEPTH_COUNT);
  assign push       = in_valid && in_ready;
  assign pop        = out_en && (cnt_reg == '0) && !fifo_empty;

  // Head is read asynchronously so a pop can emit its first bit on the same edge.
  assign head_word = mem[rd_ptr_reg];

  // Put the word into transmit order so the shifter always sends its top bit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
      if (MSB_FIRST) begin : g_msb
        assign head_ordered[gi] = head_word[gi];
      end else begin : g_lsb
        assign head_ordered[gi] = head_word[WIDTH-1-gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + (AW+1)'(1);
        2'b01:   occ_reg <= occ_reg - (AW+1)'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg      <= '0;
      cnt_reg        <= '0;
      dout_reg       <= IDLE_BIT;
      dout_valid_reg <= 1'b0;
      words_sent_reg <= '0;
    end else if (!out_en) begin
      dout_reg       <= IDLE_BIT;
      dout_valid_reg <= 1'b0;
    end else if (cnt_reg != '0) begin
      dout_reg       <= shift_reg[WIDTH-1];
      dout_valid_reg <= 1'b1;
      shift_reg      <= {shift_reg[WIDTH-2:0], 1'b0};
      cnt_reg        <= cnt_reg - CW'(1);
      if (cnt_reg == CW'(1)) begin
        words_sent_reg <= words_sent_reg + 16'd1;
      end
    end else if (!fifo_empty) begin
      dout_reg       <= head_ordered[WIDTH-1];
      dout_valid_reg <= 1'b1;
      shift_reg      <= {head_ordered[WIDTH-2:0], 1'b0};
      cnt_reg        <= LAST_CNT;
    end else begin
      dout_reg       <= IDLE_BIT;
      dout_valid_reg <= 1'b0;
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign words_sent = words_sent_reg;
  assign busy       = !fifo_empty || (cnt_reg != '0);

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: one MSB-first and one LSB-first instance.
module tb_bit_serializer;

  logic        clk;
  logic        rst;

  logic [3:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        out_en;
  logic        dout;
  logic        dout_valid;
  logic        busy;
  logic [15:0] words_sent;

  logic [3:0]  in_data_b;
  logic        in_valid_b;
  logic        in_ready_b;
  logic        out_en_b;
  logic        dout_b;
  logic        dout_valid_b;
  logic        busy_b;
  logic [15:0] words_sent_b;

  int checks;
  int failures;

  bit_serializer #(.WIDTH(4), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_en(out_en), .dout(dout), .dout_valid(dout_valid), .busy(busy), .words_sent(words_sent)
  );

  bit_serializer #(.WIDTH(4), .DEPTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_en(out_en_b), .dout(dout_b), .dout_valid(dout_valid_b), .busy(busy_b),
    .words_sent(words_sent_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [7:0] bits8;
  logic [3:0] bits4;
  logic [3:0] words [5];
  logic       en_pat [6];
  logic [1:0] exp_pat [6];

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in_data = '0; in_valid = 1'b0; out_en = 1'b0;
    in_data_b = '0; in_valid_b = 1'b0; out_en_b = 1'b0;

    // Reset and idle
    step();
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0; out_en = 1'b1; out_en_b = 1'b1;
    step();
    check_val("idle_dout", 32'(dout), 32'd0);
    check_val("idle_valid", 32'(dout_valid), 32'd0);
    check_val("idle_in_ready", 32'(in_ready), 32'd1);
    check_val("idle_busy", 32'(busy), 32'd0);
    check_val("idle_words", 32'(words_sent), 32'd0);
    $display("reset/idle transaction done");

    // Two back-to-back words, gapless
    in_valid = 1'b1; in_data = 4'b1011;
    step();
    check_val("b2b_pre_valid", 32'(dout_valid), 32'd0);
    step();
    in_valid = 1'b0;
    bits8 = 8'b1011_1011;
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("b2b_bit%0d", i), 32'({dout_valid, dout}), 32'({1'b1, bits8[7-i]}));
      step();
    end
    check_val("b2b_end_valid", 32'(dout_valid), 32'd0);
    check_val("b2b_words", 32'(words_sent), 32'd2);
    check_val("b2b_busy", 32'(busy), 32'd0);
    $display("back-to-back transaction done");

    // Fill FIFO with out_en low, fifth word waits for a pop
    words[0] = 4'b1001; words[1] = 4'b0110; words[2] = 4'b1110;
    words[3] = 4'b0011; words[4] = 4'b0101;
    out_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("fill_ready%0d", k), 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_data = words[k];
      step();
    end
    check_val("fill_full", 32'(in_ready), 32'd0);
    in_data = words[4];
    step();
    check_val("fill_held_ready", 32'(in_ready), 32'd0);
    check_val("fill_held_valid", 32'(dout_valid), 32'd0);
    check_val("fill_held_busy", 32'(busy), 32'd1);
    out_en = 1'b1;
    step();
    for (int n = 0; n < 20; n++) begin
      check_val($sformatf("fill_bit%0d", n), 32'({dout_valid, dout}),
                32'({1'b1, words[n/4][3-(n%4)]}));
      if (n == 0) check_val("fill_ready_after_pop", 32'(in_ready), 32'd1);
      if (n == 1) in_valid = 1'b0;
      step();
    end
    check_val("fill_end_valid", 32'(dout_valid), 32'd0);
    check_val("fill_words", 32'(words_sent), 32'd7);
    check_val("fill_busy", 32'(busy), 32'd0);
    $display("fifo fill transaction done");

    // Paced output with out_en toggling
    out_en = 1'b0; in_valid = 1'b1; in_data = 4'b1100;
    step();
    in_valid = 1'b0;
    en_pat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_pat = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b10, 2'b10};
    for (int i = 0; i < 6; i++) begin
      out_en = en_pat[i];
      step();
      check_val($sformatf("pace%0d", i), 32'({dout_valid, dout}), 32'(exp_pat[i]));
    end
    check_val("pace_words", 32'(words_sent), 32'd8);
    $display("paced transaction done");

    // LSB-first instance
    in_valid_b = 1'b1; in_data_b = 4'b0001;
    step();
    in_valid_b = 1'b0;
    check_val("lsb_pre_valid", 32'(dout_valid_b), 32'd0);
    step();
    bits4 = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("lsb_bit%0d", i), 32'({dout_valid_b, dout_b}), 32'({1'b1, bits4[3-i]}));
      step();
    end
    check_val("lsb_words", 32'(words_sent_b), 32'd1);
    $display("lsb-first transaction done");

    // Reset in the middle of a word
    in_valid = 1'b1; in_data = 4'b1111;
    step();
    in_valid = 1'b0;
    step();
    check_val("mid_rst_bit0", 32'({dout_valid, dout}), 32'd3);
    step();
    check_val("mid_rst_bit1", 32'({dout_valid, dout}), 32'd3);
    rst = 1'b1;
    step();
    check_val("mid_rst_valid", 32'(dout_valid), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_words", 32'(words_sent), 32'd0);
    check_val("mid_rst_ready", 32'(in_ready), 32'd0);
    check_val("mid_rst_words_b", 32'(words_sent_b), 32'd0);
    rst = 1'b0;
    step();
    check_val("post_rst_valid", 32'(dout_valid), 32'd0);
    check_val("post_rst_busy", 32'(busy), 32'd0);
    in_valid = 1'b1; in_data = 4'b0101;
    step();
    in_valid = 1'b0;
    step();
    bits4 = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("post_rst_bit%0d", i), 32'({dout_valid, dout}), 32'({1'b1, bits4[3-i]}));
      step();
    end
    check_val("post_rst_words", 32'(words_sent), 32'd1);
    $display("mid-word reset transaction done");

    // Counter wrap
    force dut.words_sent_reg = 16'hFFFF;
    step();
    release dut.words_sent_reg;
    step();
    check_val("wrap_preload", 32'(words_sent), 32'h0000FFFF);
    in_valid = 1'b1; in_data = 4'b1010;
    step();
    in_valid = 1'b0;
    step();
    bits4 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("wrap_bit%0d", i), 32'({dout_valid, dout}), 32'({1'b1, bits4[3-i]}));
      step();
    end
    check_val("wrap_words", 32'(words_sent), 32'd0);
    $display("counter wrap transaction done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
